imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, program-memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width (fixed two bytes per word).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 2_700_000, maximum idle cycles between bytes inside a frame.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe, received UART byte present.
REQ-007 SHALL have port rx_data  input  8  received byte, valid with rx_valid.
REQ-008 SHALL have port cpu_addr  input  ADDR_W  CPU fetch address (PC).
REQ-009 SHALL have port mem_ce  output  1  BSRAM chip enable.
REQ-010 SHALL have port mem_wre  output  1  BSRAM write enable.
REQ-011 SHALL have port mem_ad  output  ADDR_W  BSRAM address.
REQ-012 SHALL have port mem_din  output  DATA_W  BSRAM write data.
REQ-013 SHALL have port cpu_hold  output  1  CPU held in reset/stall while high.
REQ-014 SHALL have port load_done  output  1  last frame loaded and checksum good (level).
REQ-015 SHALL have port load_err  output  1  last frame failed (level).

Function
REQ-016 Frame format SHALL be: SYNC 0xA5, LEN N (words, 1..255), N words each low byte then high byte, CSUM = 8-bit sum mod 256 of all 2N data bytes.
REQ-017 States SHALL be IDLE, LEN, LO, HI, WRITE, CSUM, DONE, ERR.
REQ-018 IDLE/DONE/ERR: rx_data==0xA5 with rx_valid -> LEN; cpu_hold=1 from next cycle; load_done, load_err cleared; other bytes ignored.
REQ-019 LEN: N==0 -> ERR; else store N, word index=0, sum=0 -> LO.
REQ-020 LO: byte latched into mem_din[7:0], added to sum -> HI; HI: byte into mem_din[15:8], added to sum -> WRITE.
REQ-021 WRITE SHALL last exactly one cycle: mem_wre=1, mem_ad=word index; then index+1; -> CSUM if index==N-1 else LO.
REQ-022 A byte strobed during WRITE SHALL be taken as the next low byte (-> HI directly), or as CSUM byte if it was the last word; no byte lost.
REQ-023 CSUM: match -> DONE (load_done=1, cpu_hold=0); mismatch -> ERR (load_err=1, cpu_hold stays 1).
REQ-024 Timeout counter SHALL reset on every accepted byte; reaching TIMEOUT_CYC in LEN/LO/HI/CSUM -> ERR.
REQ-025 Arbitration: when cpu_hold=0, mem_ad=cpu_addr, mem_wre=0; when cpu_hold=1 and not WRITE, mem_ad=word index, mem_wre=0.
REQ-026 mem_ce SHALL be 1 in every state after reset.
REQ-027 Word index SHALL be ADDR_W bits; N≤255 guarantees no wrap; addresses ≥N untouched.
REQ-028 0xA5 inside a frame SHALL be treated as data, never as resync.

Reset
REQ-029 On rst_n low at a clock edge: state=IDLE, cpu_hold=0, load_done=0, load_err=0, mem_wre=0, mem_ce=1, mem_din=0, index/sum/timeout=0.
REQ-030 Reset mid-frame SHALL abort without further writes; already-written words remain.

Structure
REQ-031 Package imem_loader_pkg SHALL hold the state enum, SYNC_BYTE=8'hA5, default ADDR_W/DATA_W.
REQ-032 Single module, no sub-module; the UART receiver remains external.

Verification
REQ-033 Frame A5 02 A1 00 78 00 19 -> writes 0x00A1@0, 0x0078@1, load_done=1, cpu_hold=0, mem_ad follows cpu_addr.
REQ-034 Same frame with CSUM 0x1A -> load_err=1, cpu_hold=1, load_done=0.
REQ-035 A5 00 -> ERR immediately, no mem_wre pulse.
REQ-036 A5 03 then silence TIMEOUT_CYC cycles -> ERR; subsequent valid frame -> DONE.
REQ-037 Back-to-back rx_valid (byte during WRITE) with 4-word frame -> all 4 words correct.
REQ-038 rst_n low for one cycle after 2nd data byte -> IDLE, no further writes, all outputs at reset values.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART-driven instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_LO    = 3'd2,
    ST_HI    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         DEF_ADDR_W = 11;
  localparam int         DEF_DATA_W = 16;

endpackage

// File: rtl/imem_loader.sv
// Receives a framed program image over UART bytes, writes it into BSRAM and
// holds the CPU until a frame with a good checksum has been loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 2_700_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t              r_state;
  logic [7:0]          r_rem;
  logic [7:0]          r_sum;
  logic [ADDR_W-1:0]   r_idx;
  logic [TMO_W-1:0]    r_tmo;
  logic [DATA_W-1:0]   r_din;
  logic                r_hold;
  logic                r_done;
  logic                r_err;

  logic [7:0]          w_sumNext;
  logic                w_tmoHit;
  logic                w_csumOk;
  logic                w_counting;

  assign w_sumNext  = r_sum + rx_data;
  assign w_tmoHit   = (r_tmo == TMO_LAST);
  assign w_csumOk   = (rx_data == r_sum);
  assign w_counting = (r_state == ST_LEN) || (r_state == ST_LO) || (r_state == ST_HI) ||
                      (r_state == ST_WRITE) || (r_state == ST_CSUM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_din   <= '0;
      r_hold  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (rx_valid) begin
        r_tmo <= '0;
      end else if (w_counting) begin
        r_tmo <= r_tmo + 1'b1;
      end

      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            r_state <= ST_LEN;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        ST_LEN: begin
          if (rx_valid) begin
            if (rx_data == 8'd0) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else begin
              r_rem   <= rx_data;
              r_idx   <= '0;
              r_sum   <= '0;
              r_state <= ST_LO;
            end
          end else if (w_tmoHit) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end
        end
        ST_LO: begin
          if (rx_valid) begin
            r_din[7:0] <= rx_data;
            r_sum      <= w_sumNext;
            r_state    <= ST_HI;
          end else if (w_tmoHit) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end
        end
        ST_HI: begin
          if (rx_valid) begin
            r_din[15:8] <= rx_data;
            r_sum       <= w_sumNext;
            r_state     <= ST_WRITE;
          end else if (w_tmoHit) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end
        end
        // A byte arriving in the write cycle is consumed immediately so back-to-back strobes lose nothing.
        ST_WRITE: begin
          r_idx <= r_idx + 1'b1;
          r_rem <= r_rem - 8'd1;
          if (r_rem == 8'd1) begin
            if (!rx_valid) begin
              r_state <= ST_CSUM;
            end else if (w_csumOk) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end else if (rx_valid) begin
            r_din[7:0] <= rx_data;
            r_sum      <= w_sumNext;
            r_state    <= ST_HI;
          end else begin
            r_state <= ST_LO;
          end
        end
        ST_CSUM: begin
          if (rx_valid) begin
            if (w_csumOk) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end else if (w_tmoHit) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The CPU owns the memory port only while it is released.
  assign mem_ce    = 1'b1;
  assign mem_wre   = (r_state == ST_WRITE);
  assign mem_ad    = r_hold ? r_idx : cpu_addr;
  assign mem_din   = r_din;
  assign cpu_hold  = r_hold;
  assign load_done = r_done;
  assign load_err  = r_err;

endmodule
